// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_pkg                                                       |
// | Description : Shared definitions for the Wishbone arbiter slice: FSM state |
// |               encoding, bus width defaults (kept consistent with def.v),   |
// |               the timeout default and the master index type.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package wb_pkg;

  // Arbiter FSM encoding (legacy-compatible single-bit states)
  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  // Bus width defaults, mirroring address_width/data_width/select_width
  localparam int AW_DEF        = 8;
  localparam int DW_DEF        = 8;
  localparam int SW_DEF        = 1;
  localparam int NM_DEF        = 4;
  localparam int TO_CYCLES_DEF = 16;

  // Master index width: wide enough for up to four masters
  localparam int IDX_W = 2;
  typedef logic [IDX_W-1:0] idx_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_rr_pick                                                   |
// | Description : Combinational round-robin picker. Searches the request       |
// |               vector upward starting at last+1, wrapping modulo NM, and    |
// |               returns the first requester found.                           |
// | Ports       : req  [NM-1:0] in  - request vector                           |
// |               last  idx_t   in  - index of the previous owner              |
// |               gnt  [NM-1:0] out - one-hot grant (zero if no request)       |
// |               idx   idx_t   out - index of the granted requester           |
// |               any           out - at least one request present             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_rr_pick
  import wb_pkg::*;
#(
  parameter int NM = NM_DEF
) (
  input  logic [NM-1:0] req,
  input  idx_t          last,
  output logic [NM-1:0] gnt,
  output idx_t          idx,
  output logic          any
);

  localparam int PW = $clog2(NM);

  int            w_pos;
  logic [PW-1:0] w_sel;
  logic          w_found;

  assign any = |req;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_pos   = int'(last);
    w_sel   = '0;
    // Visit last+1, last+2, ... last+NM (the previous owner comes last)
    for (int k = 0; k < NM; k++) begin
      w_pos = (w_pos + 1) % NM;
      w_sel = PW'(w_pos);
      if (!w_found && req[w_sel]) begin
        w_found    = 1'b1;
        gnt[w_sel] = 1'b1;
        idx        = idx_t'(w_pos);
      end
    end
  end

endmodule : wb_rr_pick
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_arbiter                                                   |
// | Description : Round-robin Wishbone arbiter sharing one slave port among    |
// |               NM (2..4) masters. No preemption: the owner keeps the bus    |
// |               until it drops CYC. One idle cycle separates owners.         |
// | Options     : WB_ARB_TIMEOUT_EN - when defined, a stalled strobe is        |
// |               aborted with a one-cycle error after TO_CYCLES cycles.       |
// | Ports       : CLK_I, RST_I (async, active-high)                            |
// |               M_CYC_I/M_STB_I/M_WE_I [NM]   master controls                |
// |               M_ADR_I/M_DAT_I/M_SEL_I       packed master buses            |
// |               M_DAT_O, M_ACK_O, M_ERR_O     responses to masters           |
// |               GNT_O [NM]                    one-hot grant                  |
// |               S_*_O / S_DAT_I/S_ACK_I/S_ERR_I  slave side                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int SW        = SW_DEF,
  parameter int NM        = NM_DEF,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [NM-1:0]    M_CYC_I,
  input  logic [NM-1:0]    M_STB_I,
  input  logic [NM-1:0]    M_WE_I,
  input  logic [NM*AW-1:0] M_ADR_I,
  input  logic [NM*DW-1:0] M_DAT_I,
  input  logic [NM*SW-1:0] M_SEL_I,
  output logic [DW-1:0]    M_DAT_O,
  output logic [NM-1:0]    M_ACK_O,
  output logic [NM-1:0]    M_ERR_O,
  output logic [NM-1:0]    GNT_O,
  output logic [AW-1:0]    S_ADR_O,
  output logic [DW-1:0]    S_DAT_O,
  output logic [SW-1:0]    S_SEL_O,
  output logic             S_WE_O,
  output logic             S_STB_O,
  output logic             S_CYC_O,
  input  logic [DW-1:0]    S_DAT_I,
  input  logic             S_ACK_I,
  input  logic             S_ERR_I
);

  logic          r_state;
  logic [NM-1:0] r_gnt;
  idx_t          r_idx;
  idx_t          r_last;

  logic [NM-1:0] w_pick_gnt;
  idx_t          w_pick_idx;
  logic          w_any;
  logic          w_busy;
  logic          w_cyc_g;
  logic          w_stb_g;
  logic          w_timeout;

  wb_rr_pick #(
    .NM (NM)
  ) u_pick (
    .req  (M_CYC_I),
    .last (r_last),
    .gnt  (w_pick_gnt),
    .idx  (w_pick_idx),
    .any  (w_any)
  );

  assign w_busy  = (r_state == BUSY);
  assign w_cyc_g = M_CYC_I[r_idx];
  assign w_stb_g = M_STB_I[r_idx] & w_cyc_g;

`ifdef WB_ARB_TIMEOUT_EN
  // Counts stalled strobe cycles of the current owner. The counter is held
  // at zero while idle, so every new owner starts from a clean count.
  logic [7:0] r_to_cnt;
  logic       w_stall;

  assign w_stall   = w_busy & w_stb_g & ~S_ACK_I & ~S_ERR_I;
  // Fires in the TO_CYCLES-th consecutive stall cycle
  assign w_timeout = w_stall & (r_to_cnt == 8'(TO_CYCLES - 1));

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_to_cnt <= '0;
    end else if (!w_busy || S_ACK_I || S_ERR_I || w_timeout) begin
      r_to_cnt <= '0;
    end else if (w_stall) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end
`else
  logic [7:0] w_unused_to;
  assign w_unused_to = 8'(TO_CYCLES);
  assign w_timeout   = 1'b0;
`endif

  // Grant FSM: grant registered in IDLE, released when the owner drops CYC
  // (or on timeout). Leaving BUSY always passes through IDLE, which creates
  // the dead cycle between owners.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_last  <= idx_t'(NM - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt   <= w_pick_gnt;
            r_idx   <= w_pick_idx;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (!w_cyc_g || w_timeout) begin
            r_last  <= r_idx;
            r_gnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Slave-side mux: everything is forced low while idle
  always_comb begin
    S_ADR_O = '0;
    S_DAT_O = '0;
    S_SEL_O = '0;
    S_WE_O  = 1'b0;
    S_STB_O = 1'b0;
    S_CYC_O = 1'b0;
    if (w_busy) begin
      S_ADR_O = M_ADR_I[r_idx*AW +: AW];
      S_DAT_O = M_DAT_I[r_idx*DW +: DW];
      S_SEL_O = M_SEL_I[r_idx*SW +: SW];
      S_WE_O  = M_WE_I[r_idx];
      S_STB_O = w_stb_g & ~w_timeout;
      S_CYC_O = w_cyc_g & ~w_timeout;
    end
  end

  // Responses go to the owner only; error takes precedence over acknowledge
  assign M_ACK_O = w_busy ? (r_gnt & {NM{S_ACK_I & ~S_ERR_I & ~w_timeout}}) : '0;
  assign M_ERR_O = w_busy ? (r_gnt & {NM{S_ERR_I | w_timeout}}) : '0;
  assign M_DAT_O = S_DAT_I;
  assign GNT_O   = r_gnt;

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_arbiter                                                |
// | Description : Table-driven bench for wb_arbiter (4 masters, 8-bit buses)   |
// |               plus hand-written async-reset and long-stall sequences.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_arbiter;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [3:0]  M_CYC_I = '0;
  logic [3:0]  M_STB_I = '0;
  logic [3:0]  M_WE_I  = 4'b0100;             // only M2 writes
  logic [31:0] M_ADR_I = 32'h33_22_FF_10;     // M3..M0
  logic [31:0] M_DAT_I = 32'hA3_A2_A1_A0;
  logic [3:0]  M_SEL_I = 4'b1010;
  logic [7:0]  M_DAT_O;
  logic [3:0]  M_ACK_O, M_ERR_O, GNT_O;
  logic [7:0]  S_ADR_O, S_DAT_O;
  logic [0:0]  S_SEL_O;
  logic        S_WE_O, S_STB_O, S_CYC_O;
  logic [7:0]  S_DAT_I = '0;
  logic        S_ACK_I = 1'b0;
  logic        S_ERR_I = 1'b0;

  wb_arbiter dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .M_CYC_I(M_CYC_I), .M_STB_I(M_STB_I), .M_WE_I(M_WE_I),
    .M_ADR_I(M_ADR_I), .M_DAT_I(M_DAT_I), .M_SEL_I(M_SEL_I),
    .M_DAT_O(M_DAT_O), .M_ACK_O(M_ACK_O), .M_ERR_O(M_ERR_O), .GNT_O(GNT_O),
    .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_SEL_O(S_SEL_O), .S_WE_O(S_WE_O),
    .S_STB_O(S_STB_O), .S_CYC_O(S_CYC_O),
    .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I), .S_ERR_I(S_ERR_I)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic       rst;
    logic [3:0] cyc, stb;
    logic       ack, err;
    logic [7:0] sdat;
    logic [3:0] e_gnt;
    logic       e_scyc, e_sstb;
    logic [3:0] e_ack, e_err;
    logic [7:0] e_sadr;
    logic       e_swe;
    logic [7:0] e_sdo;
    logic       e_ssel;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] cyc, input logic [3:0] stb,
                     input logic ack, input logic err, input logic [7:0] sdat,
                     input logic [3:0] e_gnt, input logic e_scyc, input logic e_sstb,
                     input logic [3:0] e_ack, input logic [3:0] e_err,
                     input logic [7:0] e_sadr, input logic e_swe,
                     input logic [7:0] e_sdo, input logic e_ssel);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.sdat = sdat;
    v.e_gnt = e_gnt; v.e_scyc = e_scyc; v.e_sstb = e_sstb; v.e_ack = e_ack;
    v.e_err = e_err; v.e_sadr = e_sadr; v.e_swe = e_swe; v.e_sdo = e_sdo;
    v.e_ssel = e_ssel;
    vecs.push_back(v);
  endtask

  // Inputs change just after a rising edge; outputs are compared 1ns later
  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  initial begin : main
    int stall_err_cycle;
    bit held;

    // rst cyc stb ack err sdat | gnt scyc sstb ack err sadr swe sdo ssel
    add(0,4'h0,4'h0,0,0,8'h00, 4'h0,0,0,4'h0,4'h0,8'h00,0,8'h00,0); // 0 reset state
    add(0,4'h2,4'h2,0,0,8'h00, 4'h0,0,0,4'h0,4'h0,8'h00,0,8'h00,0); // 1 M1 requests
    add(0,4'h2,4'h2,0,0,8'h00, 4'h2,1,1,4'h0,4'h0,8'hFF,0,8'hA1,1); // 2 granted
    add(0,4'h2,4'h2,0,0,8'h00, 4'h2,1,1,4'h0,4'h0,8'hFF,0,8'hA1,1); // 3 wait
    add(0,4'h2,4'h2,1,0,8'h5A, 4'h2,1,1,4'h2,4'h0,8'hFF,0,8'hA1,1); // 4 ack 5A
    add(0,4'h0,4'h0,0,0,8'h00, 4'h2,0,0,4'h0,4'h0,8'hFF,0,8'hA1,1); // 5 M1 drops
    add(0,4'h0,4'h0,0,0,8'h00, 4'h0,0,0,4'h0,4'h0,8'h00,0,8'h00,0); // 6 idle
    add(1,4'h0,4'h0,0,0,8'h00, 4'h0,0,0,4'h0,4'h0,8'h00,0,8'h00,0); // 7 reset
    add(0,4'h5,4'h5,0,0,8'h00, 4'h0,0,0,4'h0,4'h0,8'h00,0,8'h00,0); // 8 M0+M2
    add(0,4'h5,4'h5,1,0,8'h11, 4'h1,1,1,4'h1,4'h0,8'h10,0,8'hA0,0); // 9 M0 xfer1
    add(0,4'h5,4'h5,1,0,8'h12, 4'h1,1,1,4'h1,4'h0,8'h10,0,8'hA0,0); // 10 xfer2
    add(0,4'h5,4'h5,1,0,8'h13, 4'h1,1,1,4'h1,4'h0,8'h10,0,8'hA0,0); // 11 xfer3
    add(0,4'h4,4'h4,0,0,8'h00, 4'h1,0,0,4'h0,4'h0,8'h10,0,8'hA0,0); // 12 M0 drops
    add(0,4'h5,4'h5,0,0,8'h00, 4'h0,0,0,4'h0,4'h0,8'h00,0,8'h00,0); // 13 dead, M0 again
    add(0,4'h5,4'h5,1,0,8'h00, 4'h4,1,1,4'h4,4'h0,8'h22,1,8'hA2,0); // 14 M2 xfer1
    add(0,4'h5,4'h5,1,1,8'h00, 4'h4,1,1,4'h0,4'h4,8'h22,1,8'hA2,0); // 15 ack+err
    add(0,4'h5,4'h5,1,0,8'h00, 4'h4,1,1,4'h4,4'h0,8'h22,1,8'hA2,0); // 16 xfer3
    add(0,4'h1,4'h1,0,0,8'h00, 4'h4,0,0,4'h0,4'h0,8'h22,1,8'hA2,0); // 17 M2 drops
    add(0,4'h1,4'h1,0,0,8'h00, 4'h0,0,0,4'h0,4'h0,8'h00,0,8'h00,0); // 18 dead
    add(0,4'h1,4'h1,0,0,8'h00, 4'h1,1,1,4'h0,4'h0,8'h10,0,8'hA0,0); // 19 M0 again
    add(0,4'h0,4'h0,0,0,8'h00, 4'h1,0,0,4'h0,4'h0,8'h10,0,8'hA0,0); // 20 drop
    add(0,4'h0,4'h0,0,0,8'h00, 4'h0,0,0,4'h0,4'h0,8'h00,0,8'h00,0); // 21 idle
    add(0,4'h8,4'h8,0,0,8'h00, 4'h0,0,0,4'h0,4'h0,8'h00,0,8'h00,0); // 22 M3 pulse
    add(0,4'h0,4'h0,0,0,8'h00, 4'h8,0,0,4'h0,4'h0,8'h33,0,8'hA3,1); // 23 granted, CYC low
    add(0,4'h0,4'h0,0,0,8'h00, 4'h0,0,0,4'h0,4'h0,8'h00,0,8'h00,0); // 24 released

    RST_I = 1'b1;
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b0;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      RST_I   = v.rst;
      M_CYC_I = v.cyc;
      M_STB_I = v.stb;
      S_ACK_I = v.ack;
      S_ERR_I = v.err;
      S_DAT_I = v.sdat;
      #1;
      n_vec++;
      chk($sformatf("v%0d gnt", i),  32'(GNT_O),   32'(v.e_gnt));
      chk($sformatf("v%0d scyc", i), 32'(S_CYC_O), 32'(v.e_scyc));
      chk($sformatf("v%0d sstb", i), 32'(S_STB_O), 32'(v.e_sstb));
      chk($sformatf("v%0d ack", i),  32'(M_ACK_O), 32'(v.e_ack));
      chk($sformatf("v%0d err", i),  32'(M_ERR_O), 32'(v.e_err));
      chk($sformatf("v%0d sadr", i), 32'(S_ADR_O), 32'(v.e_sadr));
      chk($sformatf("v%0d swe", i),  32'(S_WE_O),  32'(v.e_swe));
      chk($sformatf("v%0d sdo", i),  32'(S_DAT_O), 32'(v.e_sdo));
      chk($sformatf("v%0d ssel", i), 32'(S_SEL_O), 32'(v.e_ssel));
      chk($sformatf("v%0d mdat", i), 32'(M_DAT_O), 32'(v.sdat));
      @(posedge CLK_I);
      #1;
    end
    RST_I = 1'b0;
    S_ACK_I = 1'b0; S_ERR_I = 1'b0;

    // Async reset while M3 owns the bus (last = 3, so M3 is picked)
    M_CYC_I = 4'h8; M_STB_I = 4'h8;
    step();
    n_vec++;
    chk("rst_mid gnt_before", 32'(GNT_O), 32'h8);
    chk("rst_mid scyc_before", 32'(S_CYC_O), 32'h1);
    #2 RST_I = 1'b1;
    #1;
    n_vec++;
    chk("rst_mid gnt", 32'(GNT_O), 32'h0);
    chk("rst_mid scyc", 32'(S_CYC_O), 32'h0);
    chk("rst_mid sstb", 32'(S_STB_O), 32'h0);
    #1 RST_I = 1'b0;
    M_CYC_I = 4'h9; M_STB_I = 4'h9;
    step();
    n_vec++;
    chk("rst_after gnt_m0", 32'(GNT_O), 32'h1);
    M_CYC_I = 4'h0; M_STB_I = 4'h0;
    step();
    step();
    chk("rst_after idle", 32'(GNT_O), 32'h0);

    // Long stall on M2 with M1 waiting (last = 0 here, so request M2 alone first)
    M_CYC_I = 4'h4; M_STB_I = 4'h4;
    step();
    M_CYC_I = 4'h6; M_STB_I = 4'h6;
    n_vec++;
    chk("stall gnt_m2", 32'(GNT_O), 32'h4);
    stall_err_cycle = 0;
    held = 1'b1;
    for (int c = 1; c <= 110; c++) begin
      #1;
      if (M_ERR_O != 4'h0 && stall_err_cycle == 0) stall_err_cycle = c;
      if (GNT_O != 4'h4 || M_ACK_O != 4'h0) held = 1'b0;
      if (stall_err_cycle != 0) break;
      @(posedge CLK_I);
      #1;
    end
`ifdef WB_ARB_TIMEOUT_EN
    n_vec++;
    chk("timeout cycle", 32'(stall_err_cycle), 32'd16);
    chk("timeout err", 32'(M_ERR_O), 32'h4);
    chk("timeout scyc", 32'(S_CYC_O), 32'h0);
    chk("timeout sstb", 32'(S_STB_O), 32'h0);
    step();
    chk("timeout idle", 32'(GNT_O), 32'h0);
    chk("timeout err_once", 32'(M_ERR_O), 32'h0);
    step();
    chk("timeout next_m1", 32'(GNT_O), 32'h2);
`else
    n_vec++;
    chk("stall no_err", 32'(stall_err_cycle), 32'd0);
    chk("stall held", 32'(held), 32'd1);
    chk("stall gnt_end", 32'(GNT_O), 32'h4);
    chk("stall scyc_end", 32'(S_CYC_O), 32'h1);
`endif
    M_CYC_I = 4'h0; M_STB_I = 4'h0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_wb_arbiter
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin Wishbone bus arbiter sharing one slave port among up to four `wbmaster`-style masters. It samples master cycle requests, grants the bus to one master at a time, and muxes that master's address, data, select and strobe onto the slave side. It routes the slave's acknowledge and error back to the granted master only. It sits between the master cluster and the single memory/peripheral slave.

## Interface
- `AW`, default 8: address width (matches `address_width`).
- `DW`, default 8: data width (matches `data_width`).
- `SW`, default 1: select width (matches `select_width`).
- `NM`, default 4: number of masters, range 2..4.
- `TO_CYCLES`, default 16: timeout limit in cycles; used only with the timeout feature.

Ports (clock and reset first):
- `CLK_I` in 1: single clock, rising edge.
- `RST_I` in 1: reset, asynchronous, active-high.
- `M_CYC_I` in NM: per-master cycle request.
- `M_STB_I` in NM: per-master strobe.
- `M_WE_I` in NM: per-master write enable.
- `M_ADR_I` in NM*AW: packed master addresses; master i occupies bits [i*AW +: AW].
- `M_DAT_I` in NM*DW: packed master write data.
- `M_SEL_I` in NM*SW: packed master selects.
- `M_DAT_O` out DW: slave read data, broadcast to all masters.
- `M_ACK_O` out NM: per-master acknowledge.
- `M_ERR_O` out NM: per-master error.
- `GNT_O` out NM: one-hot grant; all zero when idle.
- `S_ADR_O` out AW, `S_DAT_O` out DW, `S_SEL_O` out SW, `S_WE_O` out 1, `S_STB_O` out 1, `S_CYC_O` out 1: slave-side bus.
- `S_DAT_I` in DW, `S_ACK_I` in 1, `S_ERR_I` in 1: slave responses.

## Operation
- States: `IDLE`, `BUSY`.
- `IDLE`, when any `M_CYC_I` bit is set:
  - Pick the first requester searching upward from `last+1`, wrapping modulo NM.
  - Register the one-hot grant and go to `BUSY`.
- `IDLE`, no request: stay in `IDLE`.
- `BUSY`:
  - Slave outputs come combinationally from the granted master.
  - `S_CYC_O = M_CYC_I[g]`; `S_STB_O = M_STB_I[g] & M_CYC_I[g]`.
- Responses in `BUSY`:
  - `M_ACK_O[g] = S_ACK_I & ~S_ERR_I`.
  - `M_ERR_O[g] = S_ERR_I`.
  - All other ack and error bits are 0.
  - ACK and ERR in the same cycle: ERR wins.
- `BUSY` exit: when `M_CYC_I[g]` deasserts, go to `IDLE`, set `last <= g` and clear the grant.
- Preemption: none. Requests from other masters during `BUSY` are held off; masters wait with CYC asserted.
- Idle outputs: every slave-side output is 0, `GNT_O = 0`, `M_ACK_O = 0`, `M_ERR_O = 0`. No tri-states are driven.
- `M_DAT_O = S_DAT_I` at all times.

## Timing
- Reset (asynchronous, any state):
  - State goes to `IDLE`.
  - `last` is set to NM-1, so master 0 has first priority.
  - `GNT_O` and all outputs go to 0 immediately.
- Grant latency: CYC seen at edge k in `IDLE` -> `GNT_O` and `S_CYC_O` high after edge k+1.
- Dead cycle: at least one `IDLE` cycle between consecutive grants, so `S_CYC_O` is low for at least one cycle between owners.
- Release: CYC drop sampled at edge k -> `GNT_O = 0` after edge k+1.
- Simultaneous requests are resolved by the round-robin pointer only.
- A master that drops CYC in the same cycle it is granted still receives one `BUSY` cycle, with S_CYC_O low; it then releases.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter runs in `BUSY` while `S_STB_O` is high and neither `S_ACK_I` nor `S_ERR_I` is asserted.
  - The counter clears on any ACK or ERR, and on entering `BUSY`.
  - When the count reaches `TO_CYCLES`:
    - Assert `M_ERR_O[g]` for exactly one cycle.
    - Force `S_CYC_O` and `S_STB_O` to 0 that same cycle.
    - Go to `IDLE`; rotate `last` as on a normal release.
- Undefined: the counter is not compiled in. `BUSY` waits indefinitely for the slave.

## Structure
- Shared package `wb_pkg`:
  - State encoding: `IDLE = 1'b0`, `BUSY = 1'b1`.
  - AW/DW/SW defaults, kept consistent with `def.v`.
  - `TO_CYCLES` default.
- Sub-module `wb_rr_pick`: combinational round-robin picker.
  - Inputs: request vector, `last` index.
  - Outputs: one-hot grant, grant index, `any` flag.
- The timeout counter stays inline under the macro.

## Test plan
- Single master: M1 raises CYC/STB, read from 0xFF; slave ACKs after 2 cycles with 0x5A -> `GNT_O = 4'b0010` one cycle after the request; `M_ACK_O[1]` high for 1 cycle; `M_DAT_O = 0x5A`; other acks stay 0.
- Contention and fairness: M0 and M2 request together, both hold CYC for 3 transfers each, with M0 re-requesting immediately after release -> grant order 0, 2, 0; `S_CYC_O` low for at least 1 cycle between owners.
- Error priority: slave asserts ACK and ERR in the same cycle -> `M_ERR_O[g] = 1`, `M_ACK_O = 0`.
- Reset mid-transfer: assert RST_I asynchronously while M3 is granted -> `GNT_O`, `S_CYC_O` and `S_STB_O` go to 0 before the next edge; the first grant after reset goes to M0 if M0 requests.
- Timeout (macro on, `TO_CYCLES = 16`): slave never ACKs -> `M_ERR_O[g]` pulses at cycle 16 of the stall, arbiter returns to `IDLE`, and a waiting M1 is granted next. With the macro off, the grant is held for more than 100 cycles.
